// File: rtl/acc_rmw_ctrl_pkg.sv
// Shared types for the accumulator read-modify-write controller.
// Stage structs are sized by ACC_AW/ACC_DW; the controller's AW/DW parameters default to these.
package acc_pkg;

  localparam int ACC_AW = 8;
  localparam int ACC_DW = 32;

  typedef enum logic [2:0] {
    ST_ACCUM    = 3'd0,
    ST_FLUSH    = 3'd1,
    ST_DRAIN_RD = 3'd2,
    ST_DRAIN_WT = 3'd3,
    ST_DONE     = 3'd4
  } acc_state_e;

  typedef struct packed {
    logic              valid;
    logic              first;
    logic [ACC_AW-1:0] addr;
    logic [ACC_DW-1:0] data;
  } acc_s1_t;

  typedef struct packed {
    logic              valid;
    logic [ACC_AW-1:0] addr;
    logic [ACC_DW-1:0] sum;
  } acc_s2_t;

endpackage

// File: rtl/acc_rmw_ctrl_if.sv
// Beat input, drain output and RAM port bundle of the accumulator controller.
interface acc_rmw_ctrl_if
  import acc_pkg::*;
#(
  parameter int AW = ACC_AW,
  parameter int DW = ACC_DW
) ();

  logic          in_valid;
  logic          in_ready;
  logic [AW-1:0] in_addr;
  logic [DW-1:0] in_data;
  logic          in_first;
  logic          drain_start;
  logic [AW-1:0] drain_last;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] out_data;
  logic [AW-1:0] out_addr;
  logic          busy;
  logic          done;
  logic          ram_rd_en;
  logic [AW-1:0] ram_rd_addr;
  logic [DW-1:0] ram_rd_data;
  logic          ram_wr_en;
  logic [AW-1:0] ram_wr_addr;
  logic [DW-1:0] ram_wr_data;

  modport slave (
    input  in_valid, in_addr, in_data, in_first, drain_start, drain_last,
           out_ready, ram_rd_data,
    output in_ready, out_valid, out_data, out_addr, busy, done,
           ram_rd_en, ram_rd_addr, ram_wr_en, ram_wr_addr, ram_wr_data
  );

  modport master (
    output in_valid, in_addr, in_data, in_first, drain_start, drain_last,
           out_ready, ram_rd_data,
    input  in_ready, out_valid, out_data, out_addr, busy, done,
           ram_rd_en, ram_rd_addr, ram_wr_en, ram_wr_addr, ram_wr_data
  );

endinterface

// File: rtl/acc_rmw_ctrl_fwd_stage.sv
// S1/S2 accumulate pipeline: forwarding operand select, wrapping adder and write-port drive.
module acc_fwd_stage
  import acc_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              accept,
  input  logic [ACC_AW-1:0] beat_addr,
  input  logic [ACC_DW-1:0] beat_data,
  input  logic              beat_first,
  input  logic [ACC_DW-1:0] rd_data,
  output logic              wr_en,
  output logic [ACC_AW-1:0] wr_addr,
  output logic [ACC_DW-1:0] wr_data,
  output logic              s1_valid,
  output logic              s2_valid
);

  acc_s1_t           s1_r;
  acc_s2_t           s2_r;
  logic [ACC_DW-1:0] operand_s;
  logic [ACC_DW-1:0] sum_s;

  // Stage registers: S1 holds the accepted beat, S2 mirrors the write S1 just issued.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_r <= '0;
      s2_r <= '0;
    end else begin
      s1_r.valid <= accept;
      if (accept) begin
        s1_r.first <= beat_first;
        s1_r.addr  <= beat_addr;
        s1_r.data  <= beat_data;
      end
      s2_r.valid <= s1_r.valid;
      s2_r.addr  <= s1_r.addr;
      s2_r.sum   <= sum_s;
    end
  end

  // Operand select: a write landing on the same edge as our read leaves the RAM stale, S2 covers it.
  always_comb begin
    operand_s = rd_data;
    if (s1_r.first) begin
      operand_s = '0;
    end else if (s2_r.valid && (s2_r.addr == s1_r.addr)) begin
      operand_s = s2_r.sum;
    end else begin
      operand_s = rd_data;
    end
    sum_s = operand_s + s1_r.data;
  end

  assign wr_en    = s1_r.valid;
  assign wr_addr  = s1_r.valid ? s1_r.addr : '0;
  assign wr_data  = s1_r.valid ? sum_s : '0;
  assign s1_valid = s1_r.valid;
  assign s2_valid = s2_r.valid;

endmodule

// File: rtl/acc_rmw_ctrl.sv
// Accumulator bank read-modify-write controller with drain sequencer.
// Optional ACC_CLEAR_ON_DRAIN_EN: zero each word in the bank as it is handed to the consumer.
module acc_rmw_ctrl
  import acc_pkg::*;
#(
  parameter int AW = ACC_AW,
  parameter int DW = ACC_DW
) (
  input logic           clk,
  input logic           rst,
  acc_rmw_ctrl_if.slave bus
);

  acc_state_e    state_r;
  acc_state_e    state_s;
  logic [AW-1:0] cnt_r;
  logic          wt_first_r;
  logic [DW-1:0] out_data_r;

  logic          accept_s;
  logic          out_hs_s;
  logic          clr_wr_s;
  logic          fwd_wr_en_s;
  logic [AW-1:0] fwd_wr_addr_s;
  logic [DW-1:0] fwd_wr_data_s;
  logic          s1_valid_s;
  logic          s2_valid_s;
  logic          rd_en_s;
  logic [AW-1:0] rd_addr_s;
  logic          wr_en_s;
  logic [AW-1:0] wr_addr_s;
  logic [DW-1:0] wr_data_s;
  logic          out_valid_s;

  assign accept_s = bus.in_valid && (state_r == ST_ACCUM);
  assign out_hs_s = (state_r == ST_DRAIN_WT) && bus.out_ready;

`ifdef ACC_CLEAR_ON_DRAIN_EN
  assign clr_wr_s = out_hs_s;
`else
  assign clr_wr_s = 1'b0;
`endif

  acc_fwd_stage u_fwd (
    .clk        (clk),
    .rst        (rst),
    .accept     (accept_s),
    .beat_addr  (bus.in_addr),
    .beat_data  (bus.in_data),
    .beat_first (bus.in_first),
    .rd_data    (bus.ram_rd_data),
    .wr_en      (fwd_wr_en_s),
    .wr_addr    (fwd_wr_addr_s),
    .wr_data    (fwd_wr_data_s),
    .s1_valid   (s1_valid_s),
    .s2_valid   (s2_valid_s)
  );

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= ST_ACCUM;
    end else begin
      state_r <= state_s;
    end
  end

  // Next-state logic; S2 only ever copies S1, so an empty S1 means both stages are empty past this edge.
  always_comb begin
    state_s = state_r;
    case (state_r)
      ST_ACCUM:    state_s = bus.drain_start ? ST_FLUSH : ST_ACCUM;
      ST_FLUSH:    state_s = s1_valid_s ? ST_FLUSH : ST_DRAIN_RD;
      ST_DRAIN_RD: state_s = ST_DRAIN_WT;
      ST_DRAIN_WT: begin
        if (bus.out_ready) begin
          state_s = (cnt_r == bus.drain_last) ? ST_DONE : ST_DRAIN_RD;
        end else begin
          state_s = ST_DRAIN_WT;
        end
      end
      ST_DONE:     state_s = ST_ACCUM;
      default:     state_s = ST_ACCUM;
    endcase
  end

  // Drain counter and output capture; the first DRAIN_WT cycle passes RAM data straight through.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_r      <= '0;
      wt_first_r <= 1'b0;
      out_data_r <= '0;
    end else begin
      wt_first_r <= (state_r == ST_DRAIN_RD);
      if (wt_first_r) begin
        out_data_r <= bus.ram_rd_data;
      end
      if ((state_r == ST_FLUSH) && (state_s == ST_DRAIN_RD)) begin
        cnt_r <= '0;
      end else if (out_hs_s && (cnt_r != bus.drain_last)) begin
        cnt_r <= cnt_r + {{(AW-1){1'b0}}, 1'b1};
      end
    end
  end

  // RAM port steering: beats and drain share the read port, S1 and drain-clear share the write port.
  always_comb begin
    rd_en_s   = 1'b0;
    rd_addr_s = '0;
    wr_en_s   = 1'b0;
    wr_addr_s = '0;
    wr_data_s = '0;
    if (accept_s) begin
      rd_en_s   = 1'b1;
      rd_addr_s = bus.in_addr;
    end else if (state_r == ST_DRAIN_RD) begin
      rd_en_s   = 1'b1;
      rd_addr_s = cnt_r;
    end else begin
      rd_en_s   = 1'b0;
      rd_addr_s = '0;
    end
    if (fwd_wr_en_s) begin
      wr_en_s   = 1'b1;
      wr_addr_s = fwd_wr_addr_s;
      wr_data_s = fwd_wr_data_s;
    end else if (clr_wr_s) begin
      wr_en_s   = 1'b1;
      wr_addr_s = cnt_r;
      wr_data_s = '0;
    end else begin
      wr_en_s   = 1'b0;
      wr_addr_s = '0;
      wr_data_s = '0;
    end
  end

  assign out_valid_s     = (state_r == ST_DRAIN_WT);
  assign bus.in_ready    = (state_r == ST_ACCUM);
  assign bus.out_valid   = out_valid_s;
  assign bus.out_addr    = out_valid_s ? cnt_r : '0;
  assign bus.out_data    = !out_valid_s ? '0 : (wt_first_r ? bus.ram_rd_data : out_data_r);
  assign bus.busy        = (state_r != ST_ACCUM) || s1_valid_s || s2_valid_s;
  assign bus.done        = (state_r == ST_DONE);
  assign bus.ram_rd_en   = rd_en_s;
  assign bus.ram_rd_addr = rd_addr_s;
  assign bus.ram_wr_en   = wr_en_s;
  assign bus.ram_wr_addr = wr_addr_s;
  assign bus.ram_wr_data = wr_data_s;

endmodule
